// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: raw row lines in, column drive and decoded key out.
// The master side is the scanner; the slave side is the keypad/consumer.
interface keypad_if;
   logic [3:0] row_in;
   logic [3:0] col_drive;
   logic [3:0] col;
   logic [3:0] row;
   logic       en;

   modport master (
      input  row_in,
      output col_drive,
      output col,
      output row,
      output en
   );

   modport slave (
      output row_in,
      input  col_drive,
      input  col,
      input  row,
      input  en
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces presses and
// releases, and strobes en once per accepted key with its one-hot column and row.
module keypad_scanner #(
   parameter int SCAN_DIV        = 24000,
   parameter int DEBOUNCE_CYCLES = 960000
) (
   input  logic     clk,
   input  logic     reset,
   keypad_if.master kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [3:0]       col_drive_q, col_drive_d;
   logic [3:0]       col_q, col_d;
   logic [3:0]       row_q, row_d;
   logic             en_q, en_d;
   logic [3:0]       cand_row_q, cand_row_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       rows_act;
   logic [CNT_W-1:0] cnt_next;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   // Active-low one-hot drive advances toward the higher column index.
   function automatic logic [3:0] next_col(input logic [3:0] cd);
      return {cd[2:0], cd[3]};
   endfunction

   assign rows_act = ~sync2_q;
   assign cnt_next = sat_inc(cnt_q);

   always_comb begin
      state_d     = state_q;
      sync1_d     = kp.row_in;
      sync2_d     = sync1_q;
      col_drive_d = col_drive_q;
      col_d       = col_q;
      row_d       = row_q;
      en_d        = 1'b0;
      cand_row_d  = cand_row_q;
      div_d       = div_q;
      cnt_d       = cnt_q;

      case (state_q)
         SCAN: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (is_one_hot(rows_act)) begin
                  cand_row_d = rows_act;
                  cnt_d      = '0;
                  state_d    = DEBOUNCE;
               end else begin
                  col_drive_d = next_col(col_drive_q);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DEBOUNCE: begin
            if (rows_act == cand_row_q) begin
               cnt_d = cnt_next;
               if (cnt_next == CNT_MAX) begin
                  col_d   = ~col_drive_q;
                  row_d   = cand_row_q;
                  en_d    = 1'b1;
                  state_d = HELD;
               end
            end else begin
               col_drive_d = next_col(col_drive_q);
               div_d       = '0;
               state_d     = SCAN;
            end
         end
         HELD: begin
            // Any row activity, including extra keys, keeps the current key held.
            if (rows_act == 4'b0000) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (rows_act == 4'b0000) begin
               cnt_d = cnt_next;
               if (cnt_next == CNT_MAX) begin
                  col_drive_d = next_col(col_drive_q);
                  div_d       = '0;
                  state_d     = SCAN;
               end
            end else begin
               state_d = HELD;
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         sync1_q     <= 4'b1111;
         sync2_q     <= 4'b1111;
         col_drive_q <= 4'b1110;
         col_q       <= 4'b0000;
         row_q       <= 4'b0000;
         en_q        <= 1'b0;
         cand_row_q  <= 4'b0000;
         div_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         col_drive_q <= col_drive_d;
         col_q       <= col_d;
         row_q       <= row_d;
         en_q        <= en_d;
         cand_row_q  <= cand_row_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
      end
   end

   assign kp.col_drive = col_drive_q;
   assign kp.col       = col_q;
   assign kp.row       = row_q;
   assign kp.en        = en_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a simple
// keypad model that pulls a row low only while its column is driven.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_on;
   logic [1:0] key_col;
   logic [1:0] key_row;
   logic [3:0] direct_low;
   logic [3:0] rin_m;
   int         en_count = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   keypad_if kp ();

   keypad_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp)
   );

   always #5 clk = ~clk;

   always_comb begin
      rin_m = 4'hF;
      if (key_on && (kp.col_drive[key_col] == 1'b0)) rin_m[key_row] = 1'b0;
      rin_m = rin_m & ~direct_low;
   end
   assign kp.row_in = rin_m;

   always @(posedge clk) if (kp.en === 1'b1) en_count <= en_count + 1;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      int         base;
      logic       found;
      logic [3:0] seen;
      logic [3:0] one;
      logic [3:0] exp_cd;

      one        = 4'b0001;
      reset      = 1'b1;
      key_on     = 1'b0;
      key_col    = 2'd0;
      key_row    = 2'd0;
      direct_low = 4'b0000;
      tick();
      tick();
      chk("rst_col_drive", kp.col_drive, 4'b1110);
      chk("rst_col", kp.col, 4'b0000);
      chk("rst_row", kp.row, 4'b0000);
      chk("rst_en", {3'b000, kp.en}, 4'b0000);

      // Idle rotation every 4 cycles.
      reset = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         exp_cd = ~(one << ((k / 4) % 4));
         chk("idle_col_drive", kp.col_drive, exp_cd);
      end
      chk("idle_no_en", 4'(en_count), 4'd0);

      // Key at column 2, row 1.
      base    = en_count;
      key_col = 2'd2;
      key_row = 2'd1;
      key_on  = 1'b1;
      found   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (kp.en === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk("press_en_seen", {3'b000, found}, 4'b0001);
      chk("press_col", kp.col, 4'b0100);
      chk("press_row", kp.row, 4'b0010);
      chk("press_frozen", kp.col_drive, 4'b1011);
      tick();
      chk("press_en_single", {3'b000, kp.en}, 4'b0000);

      // Long hold with an extra row appearing mid-hold.
      for (int i = 0; i < 200; i++) begin
         direct_low = (i >= 100 && i < 120) ? 4'b1000 : 4'b0000;
         tick();
      end
      chk("hold_one_en", 4'(en_count - base), 4'd1);
      chk("hold_frozen", kp.col_drive, 4'b1011);
      chk("hold_col", kp.col, 4'b0100);
      chk("hold_row", kp.row, 4'b0010);

      // Release: 2 sync + 1 detect + 8 debounce edges, then next column.
      key_on = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("release_still_frozen", kp.col_drive, 4'b1011);
      tick();
      chk("release_resume", kp.col_drive, 4'b0111);
      chk("release_no_en", 4'(en_count - base), 4'd1);

      // Bouncing press: low 3, high 1.
      base = en_count;
      seen = 4'b0000;
      for (int i = 0; i < 64; i++) begin
         direct_low = ((i % 4) != 3) ? 4'b0010 : 4'b0000;
         tick();
         seen = seen | ~kp.col_drive;
      end
      direct_low = 4'b0000;
      for (int i = 0; i < 20; i++) tick();
      chk("bounce_no_en", 4'(en_count - base), 4'd0);
      chk("bounce_scanning", seen, 4'b1111);

      // Two rows low together.
      base       = en_count;
      seen       = 4'b0000;
      direct_low = 4'b0101;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen = seen | ~kp.col_drive;
      end
      direct_low = 4'b0000;
      for (int i = 0; i < 5; i++) tick();
      chk("multi_no_en", 4'(en_count - base), 4'd0);
      chk("multi_scanning", seen, 4'b1111);
      chk("multi_col_kept", kp.col, 4'b0100);
      chk("multi_row_kept", kp.row, 4'b0010);

      // Exact latency: press right after reset, column 0 row 3.
      reset = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
      key_col = 2'd0;
      key_row = 2'd3;
      key_on  = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      chk("latency_not_early", {3'b000, kp.en}, 4'b0000);
      tick();
      chk("latency_en", {3'b000, kp.en}, 4'b0001);
      chk("latency_col", kp.col, 4'b0001);
      chk("latency_row", kp.row, 4'b1000);
      tick();
      chk("latency_en_single", {3'b000, kp.en}, 4'b0000);
      key_on = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      // Reset at debounce count 5.
      reset = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
      key_col = 2'd0;
      key_row = 2'd0;
      key_on  = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      reset  = 1'b1;
      key_on = 1'b0;
      tick();
      chk("midrst_col_drive", kp.col_drive, 4'b1110);
      chk("midrst_col", kp.col, 4'b0000);
      chk("midrst_row", kp.row, 4'b0000);
      chk("midrst_en", {3'b000, kp.en}, 4'b0000);
      reset = 1'b0;
      base  = en_count;
      for (int i = 0; i < 40; i++) tick();
      chk("midrst_no_en", 4'(en_count - base), 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
